// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller.
// Tags and valid bits live in flops. Line data lives in an external
// 16x256 SRAM that has one write port and one read port. A miss fetches
// a 32-byte line over the 256-bit dfp port, writes it into the SRAM and
// returns the requested word from the line buffer.
module icache_ctrl #(
  parameter int TAG_W  = 23,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ufp_addr,
  input  logic [3:0]            ufp_rmask,
  output logic                  ufp_ready,
  output logic [31:0]           ufp_rdata,
  output logic                  ufp_resp,
  input  logic                  inv,
  output logic [31:0]           dfp_addr,
  output logic                  dfp_read,
  input  logic [LINE_W-1:0]     dfp_rdata,
  input  logic                  dfp_resp,
  output logic                  sram_csb0,
  output logic [LINE_W/8-1:0]   sram_wmask0,
  output logic [IDX_W-1:0]      sram_addr0,
  output logic [LINE_W-1:0]     sram_din0,
  output logic                  sram_csb1,
  output logic [IDX_W-1:0]      sram_addr1,
  input  logic [LINE_W-1:0]     sram_dout1
);

  localparam int SETS = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS,
    FILL,
    COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [IDX_W-1:0]   req_idx_q, req_idx_d;
  logic [2:0]         req_wsel_q, req_wsel_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [SETS];
  logic [TAG_W-1:0]   tag_d [SETS];

  logic               hit;
  logic               accept_en;
  logic [1:0]         unused_addr_bits;

  // The byte offset within a word is not needed for whole-word fetches.
  assign unused_addr_bits = ufp_addr[1:0];

  // Lookup compares the stored tag for the latched index.
  assign hit = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);

  // Refills always target the whole line of the latched request.
  assign dfp_addr   = {req_tag_q, req_idx_q, 5'b0};
  assign sram_addr0 = req_idx_q;
  assign sram_din0  = line_q;

  // Next-state logic and state-derived port outputs.
  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_wsel_d  = req_wsel_q;
    line_d      = line_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    accept_en   = 1'b0;
    ufp_ready   = 1'b0;
    ufp_resp    = 1'b0;
    ufp_rdata   = '0;
    dfp_read    = 1'b0;
    sram_csb0   = 1'b1;
    sram_wmask0 = '0;
    sram_csb1   = 1'b1;
    sram_addr1  = req_idx_q;

    case (state_q)
      IDLE: begin
        ufp_ready = 1'b1;
        accept_en = 1'b1;
      end
      LOOKUP: begin
        if (hit) begin
          ufp_resp  = 1'b1;
          ufp_rdata = sram_dout1[{req_wsel_q, 5'b0} +: 32];
          ufp_ready = 1'b1;
          accept_en = 1'b1;
        end else begin
          state_d = MISS;
        end
      end
      MISS: begin
        dfp_read = 1'b1;
        if (dfp_resp) begin
          line_d  = dfp_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        sram_csb0          = 1'b0;
        sram_wmask0        = '1;
        tag_d[req_idx_q]   = req_tag_q;
        valid_d[req_idx_q] = 1'b1;
        state_d            = COMMIT;
      end
      COMMIT: begin
        ufp_resp  = 1'b1;
        ufp_rdata = line_q[{req_wsel_q, 5'b0} +: 32];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Invalidate takes priority over a request arriving in the same ready cycle.
    if (accept_en) begin
      if (inv) begin
        valid_d = '0;
        state_d = IDLE;
      end else if (ufp_rmask != 4'b0) begin
        req_tag_d  = ufp_addr[31 -: TAG_W];
        req_idx_d  = ufp_addr[5 +: IDX_W];
        req_wsel_d = ufp_addr[4:2];
        sram_csb1  = 1'b0;
        sram_addr1 = ufp_addr[5 +: IDX_W];
        state_d    = LOOKUP;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State, request, line buffer and tag/valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_tag_q  <= '0;
      req_idx_q  <= '0;
      req_wsel_q <= '0;
      line_q     <= '0;
      valid_q    <= '0;
      for (int i = 0; i < SETS; i++) tag_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      req_tag_q  <= req_tag_d;
      req_idx_q  <= req_idx_d;
      req_wsel_q <= req_wsel_d;
      line_q     <= line_d;
      valid_q    <= valid_d;
      for (int i = 0; i < SETS; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed checks of the instruction cache controller with
// a behavioural SRAM and a hand-driven memory port.
module tb_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic         ufp_ready;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;
  logic         inv;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         sram_csb0;
  logic [31:0]  sram_wmask0;
  logic [3:0]   sram_addr0;
  logic [255:0] sram_din0;
  logic         sram_csb1;
  logic [3:0]   sram_addr1;
  logic [255:0] sram_dout1 = '0;

  logic [255:0] mem [16];
  int           sram_writes = 0;
  logic [3:0]   last_waddr = '0;
  logic [31:0]  last_wmask = '0;

  int tests_run = 0;
  int failed = 0;

  icache_ctrl dut (
    .clk(clk), .rst(rst),
    .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask), .ufp_ready(ufp_ready),
    .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp), .inv(inv),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0),
    .sram_din0(sram_din0), .sram_csb1(sram_csb1), .sram_addr1(sram_addr1),
    .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked write port, registered read port.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      for (int b = 0; b < 32; b++)
        if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      sram_writes <= sram_writes + 1;
      last_waddr  <= sram_addr0;
      last_wmask  <= sram_wmask0;
    end
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request that is expected to miss, answers dfp_read after n
  // cycles with a line built from base, and reports what was observed.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] base, input int n,
                         output int resp_cnt, output logic [31:0] data, output int lat,
                         output int read_cnt, output logic [31:0] daddr, output int wr_cnt,
                         output logic [3:0] wr_addr, output logic [31:0] wr_mask);
    int w0;
    w0 = sram_writes;
    resp_cnt = 0; read_cnt = 0; lat = -1; data = '0; daddr = '0;
    ufp_addr = addr;
    ufp_rmask = 4'hF;
    tick();
    ufp_rmask = 4'h0;
    for (int c = 0; c < n + 6; c++) begin
      @(negedge clk);
      if (dfp_read) begin read_cnt++; daddr = dfp_addr; end
      if (ufp_resp) begin resp_cnt++; data = ufp_rdata; lat = c + 1; end
      if (dfp_read && read_cnt == n) begin dfp_resp = 1'b1; dfp_rdata = make_line(base); end
      tick();
      dfp_resp = 1'b0;
    end
    wr_cnt = sram_writes - w0;
    wr_addr = last_waddr;
    wr_mask = last_wmask;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++; if (ufp_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_ready: got %b expected 1", ufp_ready); end
    tests_run++; if (ufp_resp !== 1'b0) begin failed++; $display("[TB] FAIL reset_resp: got %b expected 0", ufp_resp); end
    tests_run++; if (ufp_rdata !== 32'h0) begin failed++; $display("[TB] FAIL reset_rdata: got %h expected 0", ufp_rdata); end
    tests_run++; if (dfp_read !== 1'b0) begin failed++; $display("[TB] FAIL reset_dfp_read: got %b expected 0", dfp_read); end
    tests_run++; if (sram_csb0 !== 1'b1) begin failed++; $display("[TB] FAIL reset_csb0: got %b expected 1", sram_csb0); end
    tests_run++; if (sram_wmask0 !== 32'h0) begin failed++; $display("[TB] FAIL reset_wmask0: got %h expected 0", sram_wmask0); end
    tests_run++; if (sram_csb1 !== 1'b1) begin failed++; $display("[TB] FAIL reset_csb1: got %b expected 1", sram_csb1); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int rc, lat, rd, wc; logic [31:0] d, da, wm; logic [3:0] wa;
    do_miss(32'h0000_0044, 32'hA000_0000, 5, rc, d, lat, rd, da, wc, wa, wm);
    tests_run++; if (rc !== 1) begin failed++; $display("[TB] FAIL cold_resp_count: got %0d expected 1", rc); end
    tests_run++; if (d !== 32'hA000_0001) begin failed++; $display("[TB] FAIL cold_rdata: got %h expected a0000001", d); end
    tests_run++; if (lat !== 8) begin failed++; $display("[TB] FAIL cold_latency: got %0d expected 8", lat); end
    tests_run++; if (rd !== 5) begin failed++; $display("[TB] FAIL cold_read_cycles: got %0d expected 5", rd); end
    tests_run++; if (da !== 32'h0000_0040) begin failed++; $display("[TB] FAIL cold_dfp_addr: got %h expected 00000040", da); end
    tests_run++; if (wc !== 1) begin failed++; $display("[TB] FAIL cold_write_count: got %0d expected 1", wc); end
    tests_run++; if (wa !== 4'd2) begin failed++; $display("[TB] FAIL cold_write_addr: got %0d expected 2", wa); end
    tests_run++; if (wm !== 32'hFFFF_FFFF) begin failed++; $display("[TB] FAIL cold_wmask: got %h expected ffffffff", wm); end
  endtask

  task automatic test_hit();
    ufp_addr = 32'h0000_005C;
    ufp_rmask = 4'hF;
    @(negedge clk);
    tests_run++; if (sram_csb1 !== 1'b0 || sram_addr1 !== 4'd2) begin failed++; $display("[TB] FAIL hit_sram_read: got csb1=%b addr1=%0d expected 0/2", sram_csb1, sram_addr1); end
    tick();
    ufp_rmask = 4'h0;
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b1) begin failed++; $display("[TB] FAIL hit_resp: got %b expected 1", ufp_resp); end
    tests_run++; if (ufp_rdata !== 32'hA000_0007) begin failed++; $display("[TB] FAIL hit_rdata: got %h expected a0000007", ufp_rdata); end
    tests_run++; if (dfp_read !== 1'b0) begin failed++; $display("[TB] FAIL hit_dfp_read: got %b expected 0", dfp_read); end
    tick();
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b0) begin failed++; $display("[TB] FAIL hit_resp_single: got %b expected 0", ufp_resp); end
    tick();
  endtask

  task automatic test_back_to_back();
    ufp_addr = 32'h0000_0040;
    ufp_rmask = 4'hF;
    tick();
    ufp_addr = 32'h0000_0044;
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b1 || ufp_rdata !== 32'hA000_0000) begin failed++; $display("[TB] FAIL b2b_word0: got resp=%b data=%h expected 1/a0000000", ufp_resp, ufp_rdata); end
    tick();
    ufp_addr = 32'h0000_0048;
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b1 || ufp_rdata !== 32'hA000_0001) begin failed++; $display("[TB] FAIL b2b_word1: got resp=%b data=%h expected 1/a0000001", ufp_resp, ufp_rdata); end
    tick();
    ufp_rmask = 4'h0;
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b1 || ufp_rdata !== 32'hA000_0002) begin failed++; $display("[TB] FAIL b2b_word2: got resp=%b data=%h expected 1/a0000002", ufp_resp, ufp_rdata); end
    tick();
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b0) begin failed++; $display("[TB] FAIL b2b_end: got resp=%b expected 0", ufp_resp); end
    tick();
  endtask

  task automatic test_conflict();
    int rc, lat, rd, wc; logic [31:0] d, da, wm; logic [3:0] wa;
    do_miss(32'h0000_0240, 32'hB000_0000, 3, rc, d, lat, rd, da, wc, wa, wm);
    tests_run++; if (rd !== 3) begin failed++; $display("[TB] FAIL conflict_miss: got %0d read cycles expected 3", rd); end
    tests_run++; if (da !== 32'h0000_0240) begin failed++; $display("[TB] FAIL conflict_dfp_addr: got %h expected 00000240", da); end
    tests_run++; if (d !== 32'hB000_0000 || rc !== 1) begin failed++; $display("[TB] FAIL conflict_rdata: got %h x%0d expected b0000000 x1", d, rc); end
    tests_run++; if (lat !== 6 || wa !== 4'd2) begin failed++; $display("[TB] FAIL conflict_lat_waddr: got %0d/%0d expected 6/2", lat, wa); end
    do_miss(32'h0000_0040, 32'hA000_0000, 1, rc, d, lat, rd, da, wc, wa, wm);
    tests_run++; if (rd !== 1) begin failed++; $display("[TB] FAIL conflict_remiss: got %0d read cycles expected 1", rd); end
    tests_run++; if (d !== 32'hA000_0000 || lat !== 4) begin failed++; $display("[TB] FAIL conflict_remiss_data: got %h lat %0d expected a0000000 lat 4", d, lat); end
  endtask

  task automatic test_invalidate();
    int rc, lat, rd, wc; logic [31:0] d, da, wm; logic [3:0] wa;
    inv = 1'b1;
    ufp_addr = 32'h0000_0040;
    ufp_rmask = 4'hF;
    @(negedge clk);
    tests_run++; if (sram_csb1 !== 1'b1 || ufp_ready !== 1'b1) begin failed++; $display("[TB] FAIL inv_drop: got csb1=%b ready=%b expected 1/1", sram_csb1, ufp_ready); end
    tick();
    inv = 1'b0;
    ufp_rmask = 4'h0;
    @(negedge clk);
    tests_run++; if (ufp_resp !== 1'b0) begin failed++; $display("[TB] FAIL inv_no_resp: got %b expected 0", ufp_resp); end
    tick();
    do_miss(32'h0000_0040, 32'hA000_0000, 2, rc, d, lat, rd, da, wc, wa, wm);
    tests_run++; if (rd !== 2) begin failed++; $display("[TB] FAIL inv_remiss: got %0d read cycles expected 2", rd); end
    tests_run++; if (d !== 32'hA000_0000 || rc !== 1) begin failed++; $display("[TB] FAIL inv_remiss_data: got %h x%0d expected a0000000 x1", d, rc); end
  endtask

  task automatic test_reset_mid_miss();
    int w0, rc, lat, rd, wc; logic [31:0] d, da, wm; logic [3:0] wa;
    ufp_addr = 32'h0000_0064;
    ufp_rmask = 4'hF;
    tick();
    ufp_rmask = 4'h0;
    tick();
    @(negedge clk);
    tests_run++; if (dfp_read !== 1'b1) begin failed++; $display("[TB] FAIL rstmiss_in_miss: got dfp_read=%b expected 1", dfp_read); end
    w0 = sram_writes;
    #2 rst = 1'b1;
    #1;
    tests_run++; if (dfp_read !== 1'b0) begin failed++; $display("[TB] FAIL rstmiss_dfp_read: got %b expected 0", dfp_read); end
    tests_run++; if (ufp_ready !== 1'b1 || sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || sram_wmask0 !== 32'h0) begin failed++; $display("[TB] FAIL rstmiss_outputs: got ready=%b csb0=%b csb1=%b wmask=%h expected 1/1/1/0", ufp_ready, sram_csb0, sram_csb1, sram_wmask0); end
    tick();
    rst = 1'b0;
    dfp_resp = 1'b1;
    dfp_rdata = make_line(32'hDEAD_0000);
    rc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ufp_resp) rc++;
      tick();
      dfp_resp = 1'b0;
    end
    tests_run++; if (rc !== 0) begin failed++; $display("[TB] FAIL rstmiss_no_resp: got %0d responses expected 0", rc); end
    tests_run++; if (sram_writes !== w0) begin failed++; $display("[TB] FAIL rstmiss_no_write: got %0d writes expected %0d", sram_writes, w0); end
    do_miss(32'h0000_005C, 32'hC000_0000, 1, rc, d, lat, rd, da, wc, wa, wm);
    tests_run++; if (rd !== 1 || d !== 32'hC000_0007) begin failed++; $display("[TB] FAIL rstmiss_valids_cleared: got reads=%0d data=%h expected 1/c0000007", rd, d); end
  endtask

  initial begin
    rst = 1'b1;
    ufp_addr = '0;
    ufp_rmask = '0;
    inv = 1'b0;
    dfp_rdata = '0;
    dfp_resp = 1'b0;
    tick();
    test_reset();
    tick();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_reset_mid_miss();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller that sequences the 16×256-bit `icache_data_array` SRAM. It keeps tag and valid state in flops and services 32-bit fetch requests from the frontend. On a miss it fetches a 32-byte line over a 256-bit memory port, fills the SRAM, and returns the requested word. It sits between the fetch stage (ufp side) and the memory arbiter/bus adapter (dfp side).

## Interface
- `TAG_W`, 23: tag bits, addr[31:9]
- `IDX_W`, 4: index bits, addr[8:5]; 16 sets, matches the SRAM depth
- `LINE_W`, 256: line width; offset is addr[4:0]
- `clk`  in  1  single clock; also drives SRAM clk0/clk1
- `rst`  in  1  asynchronous, active-high reset
- `ufp_addr`  in  32  fetch address; addr[1:0] ignored
- `ufp_rmask`  in  4  nonzero = request; sampled only while `ufp_ready`=1
- `ufp_ready`  out  1  controller can accept a request this cycle
- `ufp_rdata`  out  32  fetched word; 0 when `ufp_resp`=0
- `ufp_resp`  out  1  one-cycle response strobe
- `inv`  in  1  invalidate all lines; sampled only while `ufp_ready`=1
- `dfp_addr`  out  32  line address {tag, index, 5'b0}
- `dfp_read`  out  1  held high until `dfp_resp`
- `dfp_rdata`  in  256  fill line; valid with `dfp_resp`
- `dfp_resp`  in  1  one-cycle fill-complete strobe
- `sram_csb0`  out  1  SRAM write-port chip select, active low
- `sram_wmask0`  out  32  SRAM byte write mask
- `sram_addr0`  out  4  SRAM write address
- `sram_din0`  out  256  SRAM write data
- `sram_csb1`  out  1  SRAM read-port chip select, active low
- `sram_addr1`  out  4  SRAM read address
- `sram_dout1`  in  256  SRAM read data; valid the cycle after `csb1`=0

## Operation
- States: IDLE, LOOKUP, MISS, FILL, COMMIT.
- Request register holds the accepted tag, index, and word select (addr[4:2]).
- **IDLE**
  - `ufp_ready`=1.
  - If `inv`=1: clear all 16 valid bits and stay in IDLE. Any same-cycle request is dropped.
  - Otherwise, if `ufp_rmask`≠0: latch the request, drive `sram_csb1`=0 and `sram_addr1`=addr[8:5], then go to LOOKUP.
- **LOOKUP**
  - Hit = valid[idx] && tag[idx]==req_tag.
  - On hit:
    - `ufp_resp`=1.
    - `ufp_rdata`=`sram_dout1`[32*wsel +: 32].
    - `ufp_ready`=1.
    - A new request in the same cycle is accepted as in IDLE (csb1 low, stay in LOOKUP). `inv` goes to IDLE with valids cleared.
    - With neither, go to IDLE.
  - On miss: `ufp_ready`=0, go to MISS.
- **MISS**
  - `dfp_read`=1, `dfp_addr`={req_tag, req_idx, 5'b0}.
  - On `dfp_resp`: capture `dfp_rdata` into the line buffer, go to FILL.
- **FILL**
  - `sram_csb0`=0, `sram_wmask0`=all ones, `sram_addr0`=req_idx, `sram_din0`=line buffer.
  - Write tag[idx]=req_tag and valid[idx]=1.
  - Go to COMMIT.
- **COMMIT**
  - The SRAM commits the write at the end of this cycle.
  - `ufp_resp`=1, `ufp_rdata` taken from the line buffer.
  - `ufp_ready`=0. Go to IDLE.
- SRAM ports are idle when not driven: `csb0`=1, `wmask0`=0, `csb1`=1. Address and data outputs are don't-care but must be stable (no X).

## Timing
- Reset values: state IDLE, all valid=0, `ufp_resp`=0, `ufp_rdata`=0, `ufp_ready`=1, `dfp_read`=0, `sram_csb0`=1, `sram_wmask0`=0, `sram_csb1`=1.
- Hit latency: response in the cycle after acceptance. Back-to-back hits sustain 1 request/cycle.
- Miss latency: acceptance → LOOKUP → MISS (≥1 cycle, until `dfp_resp`) → FILL → COMMIT response. That is N+3 cycles after acceptance, where N = cycles in MISS.
- `dfp_read` asserts combinationally from the state in the first MISS cycle and deasserts in the cycle after `dfp_resp`.
- `dfp_resp` outside MISS is ignored.
- SRAM write is issued in FILL and committed at the COMMIT clock edge. A request accepted in the IDLE cycle after COMMIT reads the new data.
- Tag/valid updates in FILL are visible to the next LOOKUP.
- `inv` and request in the same ready cycle: `inv` wins and the request is not accepted.
- Async `rst` mid-miss:
  - `dfp_read` drops immediately.
  - All valids are cleared.
  - No `ufp_resp` is issued for the abandoned request.
  - A late `dfp_resp` is ignored.
- `ufp_resp` is never asserted for more than one cycle per accepted request.

## Test plan
- Cold miss: request 0x0000_0044 (idx 2, wsel 1). Memory returns a line whose word k = 0xA000_0000+k after 5 cycles of `dfp_read`. Expect `dfp_addr`=0x0000_0040, one SRAM write with wmask 0xFFFF_FFFF to addr 2, and `ufp_rdata`=0xA000_0001 in COMMIT.
- Hit after fill: request 0x0000_005C. Expect `ufp_resp` in the next cycle, `ufp_rdata`=0xA000_0007, `dfp_read` never asserted.
- Back-to-back hits: requests 0x40, 0x44, 0x48 on consecutive cycles. Expect three consecutive `ufp_resp` cycles with words 0, 1, 2.
- Conflict miss: request 0x0000_0240 (same idx 2, different tag). Expect a miss, `dfp_addr`=0x0000_0240, and the line replaced. A following request to 0x40 misses again.
- Invalidate: `inv` pulse in IDLE together with a request to 0x40. Expect the request dropped; the re-issued 0x40 misses with `dfp_read`=1.
- Reset mid-miss: assert `rst` while `dfp_read`=1, then pulse `dfp_resp`. Expect no `ufp_resp`, no SRAM write, and all outputs at reset values.
